ff_write_arbiter: RTL and testbench

//  Shares one clock-enabled flip-flop register (D/CE in, Q out) between NREQ requesters.

---
 rtl/ff_write_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_ff_write_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ff_write_arbiter.sv
// Round-robin write arbiter for one shared clock-enabled register, with locked bursts and timeout.
// Optional per-requester grant counters on GNT_CNT when FF_ARB_GNT_COUNT_EN is defined.
module ff_write_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 1,
  parameter int TIMEOUT = 15
) (
  input  logic               CK,
  input  logic               RST,
  input  logic [NREQ-1:0]    REQ,
  input  logic [NREQ-1:0]    LOCK,
  input  logic [NREQ*DW-1:0] D_IN,
  output logic [NREQ-1:0]    GNT,
  output logic               CE,
  output logic [DW-1:0]      D,
  output logic               TMO
`ifdef FF_ARB_GNT_COUNT_EN
  ,
  output logic [NREQ*8-1:0]  GNT_CNT
`endif
);

  localparam int unsigned NR = NREQ;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LOCKED, BACKOFF} state_t;

  state_t            state_q, state_n;
  logic [NREQ-1:0]   gnt_q, gnt_n;
  logic              ce_q, ce_n;
  logic [DW-1:0]     d_q, d_n;
  logic              tmo_q, tmo_n;
  logic [PW-1:0]     ptr_q, ptr_n;
  logic [CW-1:0]     cnt_q, cnt_n;
  logic [PW-1:0]     own_q, own_n;
  logic              excl_q, excl_n;

  logic [NREQ-1:0]   own_mask;
  logic [NREQ-1:0]   elig;
  logic              win_vld;
  logic [PW-1:0]     win_idx;
  logic [PW-1:0]     nxt_ptr;
  logic [DW-1:0]     win_d;
  logic [DW-1:0]     own_d;
  logic              arb;

  // A requester released by timeout is skipped once, but only if someone else wants the register.
  always_comb begin
    own_mask = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      own_mask[k] = (PW'(k) == own_q);
    end
    elig = REQ;
    if (excl_q && ((REQ & ~own_mask) != '0)) begin
      elig = REQ & ~own_mask;
    end
  end

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      if (!win_vld && elig[(32'(ptr_q) + k) % NR]) begin
        win_vld = 1'b1;
        win_idx = PW'((32'(ptr_q) + k) % NR);
      end
    end
    nxt_ptr = (win_idx == PW'(NR - 1)) ? '0 : win_idx + 1'b1;
  end

  always_comb begin
    win_d = '0;
    own_d = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      if (PW'(k) == win_idx) win_d = D_IN[k*DW +: DW];
      if (PW'(k) == own_q)   own_d = D_IN[k*DW +: DW];
    end
  end

  always_comb begin
    state_n = state_q;
    gnt_n   = gnt_q;
    ce_n    = ce_q;
    d_n     = d_q;
    tmo_n   = 1'b0;
    ptr_n   = ptr_q;
    cnt_n   = cnt_q;
    own_n   = own_q;
    excl_n  = excl_q;
    arb     = 1'b0;

    unique case (state_q)
      IDLE: arb = 1'b1;
      LOCKED: begin
        if (!LOCK[own_q]) begin
          arb = 1'b1;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          state_n = BACKOFF;
          gnt_n   = '0;
          ce_n    = 1'b0;
          tmo_n   = 1'b1;
          cnt_n   = '0;
          excl_n  = 1'b1;
        end else begin
          ce_n  = REQ[own_q];
          if (REQ[own_q]) d_n = own_d;
          cnt_n = cnt_q + 1'b1;
        end
      end
      BACKOFF: begin
        state_n = IDLE;
        gnt_n   = '0;
        ce_n    = 1'b0;
      end
      default: state_n = IDLE;
    endcase

    // Lock release re-arbitrates in the same edge, so this path is shared with IDLE.
    if (arb) begin
      state_n = IDLE;
      cnt_n   = '0;
      if (win_vld) begin
        gnt_n          = '0;
        gnt_n[win_idx] = 1'b1;
        ce_n           = 1'b1;
        d_n            = win_d;
        ptr_n          = nxt_ptr;
        own_n          = win_idx;
        excl_n         = 1'b0;
        if (LOCK[win_idx]) begin
          state_n = LOCKED;
          cnt_n   = CW'(1);
        end
      end else begin
        gnt_n = '0;
        ce_n  = 1'b0;
      end
    end
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ce_q    <= 1'b0;
      d_q     <= '0;
      tmo_q   <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      own_q   <= '0;
      excl_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      gnt_q   <= gnt_n;
      ce_q    <= ce_n;
      d_q     <= d_n;
      tmo_q   <= tmo_n;
      ptr_q   <= ptr_n;
      cnt_q   <= cnt_n;
      own_q   <= own_n;
      excl_q  <= excl_n;
    end
  end

  assign GNT = gnt_q;
  assign CE  = ce_q;
  assign D   = d_q;
  assign TMO = tmo_q;

`ifdef FF_ARB_GNT_COUNT_EN
  logic [NREQ*8-1:0] gcnt_q;

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      gcnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NR; i++) begin
        if (gnt_q[i] && ce_q && (gcnt_q[i*8 +: 8] != 8'hFF)) begin
          gcnt_q[i*8 +: 8] <= gcnt_q[i*8 +: 8] + 8'd1;
        end
      end
    end
  end

  assign GNT_CNT = gcnt_q;
`endif

endmodule

// File: tb/tb_ff_write_arbiter.sv
// Directed bench for ff_write_arbiter: vector table plus reset, shared-register, timeout and counter sequences.
module tb_ff_write_arbiter;

  logic       CK = 1'b0;
  logic       RST;
  logic [3:0] REQ, LOCK, D_IN;
  logic [3:0] GNT;
  logic       CE, D, TMO;
`ifdef FF_ARB_GNT_COUNT_EN
  logic [31:0] GNT_CNT;
`endif
  logic       q_reg;

  int n_tests = 0;
  int n_fail  = 0;

  ff_write_arbiter #(.NREQ(4), .DW(1), .TIMEOUT(15)) dut (
    .CK(CK), .RST(RST), .REQ(REQ), .LOCK(LOCK), .D_IN(D_IN),
    .GNT(GNT), .CE(CE), .D(D), .TMO(TMO)
`ifdef FF_ARB_GNT_COUNT_EN
    , .GNT_CNT(GNT_CNT)
`endif
  );

  always #5 CK = ~CK;

  // The shared register being written through CE/D.
  always_ff @(posedge CK) if (CE) q_reg <= D;

  typedef struct {
    logic [3:0] req;
    logic [3:0] lock;
    logic [3:0] din;
    logic [3:0] gnt;
    logic       ce;
    logic       d;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic [3:0] di);
    REQ  = r;
    LOCK = l;
    D_IN = di;
  endtask

  initial begin
    // round-robin from PTR=0, D_IN=0101
    vecs[0]  = '{4'b1111, 4'b0000, 4'b0101, 4'b0001, 1'b1, 1'b1};
    vecs[1]  = '{4'b1111, 4'b0000, 4'b0101, 4'b0010, 1'b1, 1'b0};
    vecs[2]  = '{4'b1111, 4'b0000, 4'b0101, 4'b0100, 1'b1, 1'b1};
    vecs[3]  = '{4'b1111, 4'b0000, 4'b0101, 4'b1000, 1'b1, 1'b0};
    vecs[4]  = '{4'b1111, 4'b0000, 4'b0101, 4'b0001, 1'b1, 1'b1};
    vecs[5]  = '{4'b1111, 4'b0000, 4'b0101, 4'b0010, 1'b1, 1'b0};
    vecs[6]  = '{4'b1111, 4'b0000, 4'b0101, 4'b0100, 1'b1, 1'b1};
    vecs[7]  = '{4'b1111, 4'b0000, 4'b0101, 4'b1000, 1'b1, 1'b0};
    // single write, then idle with D held
    vecs[8]  = '{4'b0001, 4'b0000, 4'b0001, 4'b0001, 1'b1, 1'b1};
    vecs[9]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1};
    // locked burst by requester 1 (PTR=1), then release re-arbitrates to 0
    vecs[10] = '{4'b0011, 4'b0010, 4'b0010, 4'b0010, 1'b1, 1'b1};
    vecs[11] = '{4'b0011, 4'b0010, 4'b0010, 4'b0010, 1'b1, 1'b1};
    vecs[12] = '{4'b0011, 4'b0010, 4'b0010, 4'b0010, 1'b1, 1'b1};
    vecs[13] = '{4'b0011, 4'b0010, 4'b0010, 4'b0010, 1'b1, 1'b1};
    vecs[14] = '{4'b0011, 4'b0000, 4'b0001, 4'b0001, 1'b1, 1'b1};
    vecs[15] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1};
    // lock by 2: owner drops REQ (CE=0, GNT held), others ignored, release to 3
    vecs[16] = '{4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b0};
    vecs[17] = '{4'b1000, 4'b0100, 4'b1000, 4'b0100, 1'b0, 1'b0};
    vecs[18] = '{4'b1100, 4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b1};
    vecs[19] = '{4'b1000, 4'b0000, 4'b1000, 4'b1000, 1'b1, 1'b1};
    vecs[20] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1};

    RST = 1'b1;
    drive(4'b0000, 4'b0000, 4'b0000);
    step();
    step();
    chk("reset_gnt", 32'(GNT), 32'h0);
    chk("reset_ce",  32'(CE),  32'h0);
    chk("reset_d",   32'(D),   32'h0);
    chk("reset_tmo", 32'(TMO), 32'h0);
    RST = 1'b0;

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].req, vecs[i].lock, vecs[i].din);
      step();
      chk($sformatf("vec%0d_gnt", i), 32'(GNT), 32'(vecs[i].gnt));
      chk($sformatf("vec%0d_ce", i),  32'(CE),  32'(vecs[i].ce));
      chk($sformatf("vec%0d_d", i),   32'(D),   32'(vecs[i].d));
      chk($sformatf("vec%0d_tmo", i), 32'(TMO), 32'h0);
    end

    // shared register Q follows one edge after CE/D
    drive(4'b0001, 4'b0000, 4'b0000);
    step();
    chk("wr0_gnt", 32'(GNT), 32'h1);
    chk("wr0_d",   32'(D),   32'h0);
    drive(4'b0000, 4'b0000, 4'b0000);
    step();
    chk("wr0_q",   32'(q_reg), 32'h0);
    drive(4'b0001, 4'b0000, 4'b0001);
    step();
    chk("wr1_ce",  32'(CE),    32'h1);
    chk("wr1_d",   32'(D),     32'h1);
    chk("wr1_q_before", 32'(q_reg), 32'h0);
    drive(4'b0000, 4'b0000, 4'b0000);
    step();
    chk("wr1_q_after",  32'(q_reg), 32'h1);

    // timeout: requester 2 locked with 3 pending, PTR=1
    drive(4'b1100, 4'b0100, 4'b0100);
    for (int i = 0; i < 15; i++) begin
      step();
      chk($sformatf("lock_c%0d_gnt", i), 32'(GNT), 32'h4);
      chk($sformatf("lock_c%0d_ce", i),  32'(CE),  32'h1);
      chk($sformatf("lock_c%0d_tmo", i), 32'(TMO), 32'h0);
    end
    step();
    chk("tmo_pulse_tmo", 32'(TMO), 32'h1);
    chk("tmo_pulse_gnt", 32'(GNT), 32'h0);
    chk("tmo_pulse_ce",  32'(CE),  32'h0);
    step();
    chk("backoff_tmo", 32'(TMO), 32'h0);
    chk("backoff_gnt", 32'(GNT), 32'h0);
    chk("backoff_ce",  32'(CE),  32'h0);
    step();
    chk("after_tmo_gnt", 32'(GNT), 32'h8);
    chk("after_tmo_d",   32'(D),   32'h0);
    step();
    chk("relock_gnt", 32'(GNT), 32'h4);
    chk("relock_d",   32'(D),   32'h1);

    // asynchronous reset mid-burst, observed before the next edge
    #2;
    RST = 1'b1;
    #1;
    chk("async_rst_gnt", 32'(GNT), 32'h0);
    chk("async_rst_ce",  32'(CE),  32'h0);
    chk("async_rst_d",   32'(D),   32'h0);
    chk("async_rst_tmo", 32'(TMO), 32'h0);
    drive(4'b0000, 4'b0000, 4'b0000);
    step();
    chk("rst_hold_gnt", 32'(GNT), 32'h0);
    RST = 1'b0;
    drive(4'b1111, 4'b0000, 4'b1111);
    step();
    chk("post_rst_ptr_gnt", 32'(GNT), 32'h1);

`ifdef FF_ARB_GNT_COUNT_EN
    drive(4'b0001, 4'b0000, 4'b0001);
    for (int i = 0; i < 300; i++) step();
    drive(4'b0000, 4'b0000, 4'b0000);
    step();
    chk("gcnt0_sat",   32'(GNT_CNT[7:0]),  32'd255);
    chk("gcnt_others", 32'(GNT_CNT[31:8]), 32'h0);
    RST = 1'b1;
    #1;
    chk("gcnt_rst", GNT_CNT, 32'h0);
    RST = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
